// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the serial subtractor.
// The master side presents operands and consumes results; the slave side is the subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf, zero
    );
endinterface

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: a - b - bin, LSB-first, DIGIT bits per clock through a
// chain of full-subtract cells, with difference, borrow, overflow and zero flags.
module serial_subtractor #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = $clog2(STEPS + 1);

    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_subtractor: need WIDTH >= 2, 1 <= DIGIT <= WIDTH, WIDTH %% DIGIT == 0");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             brw_q, brw_d, amsb_q, amsb_d, bmsb_q, bmsb_d;
    logic             bout_q, bout_d, ovf_q, ovf_d, zero_q, zero_d;

    logic [DIGIT-1:0] dig;
    logic             br_out;
    logic [WIDTH-1:0] res_nxt;
    logic             last;

    // Ripple through DIGIT full-subtract cells starting from the stored borrow.
    always_comb begin
        dig    = '0;
        br_out = brw_q;
        for (int i = 0; i < DIGIT; i++) begin
            dig[i] = a_q[i] ^ b_q[i] ^ br_out;
            br_out = (~a_q[i] & b_q[i]) | (~a_q[i] & br_out) | (b_q[i] & br_out);
        end
    end

    if (DIGIT == WIDTH) begin : g_one_step
        assign res_nxt = dig;
    end else begin : g_multi_step
        assign res_nxt = {dig, res_q[WIDTH-1:DIGIT]};
    end

    assign last = (cnt_q == CW'(STEPS - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        brw_d   = brw_q;
        amsb_d  = amsb_q;
        bmsb_d  = bmsb_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    brw_d   = bus.bin;
                    amsb_d  = bus.a[WIDTH-1];
                    bmsb_d  = bus.b[WIDTH-1];
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                res_d = res_nxt;
                brw_d = br_out;
                cnt_d = cnt_q + CW'(1);
                // Published results only change here, so they stay put while RUN shifts.
                if (last) begin
                    diff_d  = res_nxt;
                    bout_d  = br_out;
                    ovf_d   = (amsb_q != bmsb_q) && (res_nxt[WIDTH-1] != amsb_q);
                    zero_d  = (res_nxt == '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            amsb_q  <= amsb_d;
            bmsb_q  <= bmsb_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    // in_ready is gated by rst_n so it reads 0 for the whole reset window.
    assign bus.in_ready  = rst_n && (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor: an 8-bit DIGIT=1 instance for
// directed cases, and four 16-bit instances (DIGIT 1/2/4/16) run in lock-step on random operands.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    serial_subtractor_if #(.WIDTH(8)) sif8 ();
    serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut8 (.clk(clk), .rst_n(rst_n), .bus(sif8.slave));

    logic        sv_iv, sv_bin, sv_ordy;
    logic [15:0] sv_a, sv_b;
    logic [3:0]  sw_ov, sw_rdy, sw_bout, sw_ovf, sw_zero;
    logic [15:0] sw_diff [4];

    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int DG = (g == 3) ? 16 : (1 << g);
        serial_subtractor_if #(.WIDTH(16)) sif ();
        serial_subtractor #(.WIDTH(16), .DIGIT(DG)) dut (.clk(clk), .rst_n(rst_n), .bus(sif.slave));
        assign sif.in_valid  = sv_iv;
        assign sif.a         = sv_a;
        assign sif.b         = sv_b;
        assign sif.bin       = sv_bin;
        assign sif.out_ready = sv_ordy;
        assign sw_ov[g]      = sif.out_valid;
        assign sw_rdy[g]     = sif.in_ready;
        assign sw_diff[g]    = sif.diff;
        assign sw_bout[g]    = sif.bout;
        assign sw_ovf[g]     = sif.ovf;
        assign sw_zero[g]    = sif.zero;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain arithmetic on w-bit unsigned operands.
    function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic bi, output logic [31:0] d, output logic bo,
                                  output logic ov, output logic z);
        logic [32:0] full;
        logic [31:0] mask;
        mask = (32'h1 << w) - 32'h1;
        full = {1'b0, a} - {1'b0, b} - {32'h0, bi};
        d    = full[31:0] & mask;
        bo   = ({1'b0, a} < ({1'b0, b} + {32'h0, bi}));
        ov   = (a[w-1] != b[w-1]) && (d[w-1] != a[w-1]);
        z    = (d == 32'h0);
    endfunction

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                        input logic [7:0] ed, input logic eb, input logic eo, input logic ez);
        int lat;
        bit seen;
        lat = 0;
        while (!sif8.in_ready && lat < 20) begin tick(); lat++; end
        chk("r8_in_ready", sif8.in_ready, 1);
        sif8.a = a; sif8.b = b; sif8.bin = bi; sif8.in_valid = 1'b1; sif8.out_ready = 1'b1;
        tick();
        sif8.in_valid = 1'b0; sif8.a = ~a; sif8.b = ~b; sif8.bin = ~bi;
        seen = 1'b0; lat = 0;
        while (!seen && lat < 40) begin tick(); lat++; seen = sif8.out_valid; end
        chk("r8_latency", lat, 8);
        chk("r8_diff", sif8.diff, ed);
        chk("r8_bout", sif8.bout, eb);
        chk("r8_ovf", sif8.ovf, eo);
        chk("r8_zero", sif8.zero, ez);
        tick();
        chk("r8_hs_out_valid", sif8.out_valid, 0);
        chk("r8_hs_in_ready", sif8.in_ready, 1);
        chk("r8_diff_retained", sif8.diff, ed);
    endtask

    initial begin
        logic [31:0] md;
        logic        mb, mo, mz;
        logic [7:0]  hd;
        logic        hb, ho, hz;
        int          lat [4];
        bit          done [4];
        bit          all_done;
        int          cyc;

        sif8.in_valid = 1'b0; sif8.a = '0; sif8.b = '0; sif8.bin = 1'b0; sif8.out_ready = 1'b0;
        sv_iv = 1'b0; sv_a = '0; sv_b = '0; sv_bin = 1'b0; sv_ordy = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #20;
        chk("rst_in_ready", sif8.in_ready, 0);
        chk("rst_out_valid", sif8.out_valid, 0);
        chk("rst_diff", sif8.diff, 0);
        chk("rst_flags", {sif8.bout, sif8.ovf, sif8.zero}, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", sif8.in_ready, 1);

        run8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
        run8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0);
        run8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        run8(8'h07, 8'h06, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        run8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
        run8(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0);

        // Backpressure: 0x9C - 0x21 - 1 = 0x7A, held for 5 clocks while inputs churn.
        sif8.a = 8'h9C; sif8.b = 8'h21; sif8.bin = 1'b1; sif8.out_ready = 1'b0; sif8.in_valid = 1'b1;
        tick();
        sif8.in_valid = 1'b0;
        cyc = 0;
        while (!sif8.out_valid && cyc < 40) begin tick(); cyc++; end
        chk("bp_latency", cyc, 8);
        hd = sif8.diff; hb = sif8.bout; ho = sif8.ovf; hz = sif8.zero;
        chk("bp_diff", hd, 8'h7A);
        for (int i = 0; i < 5; i++) begin
            sif8.in_valid = ~sif8.in_valid;
            sif8.a = 8'($urandom); sif8.b = 8'($urandom); sif8.bin = 1'($urandom);
            tick();
            chk("bp_out_valid", sif8.out_valid, 1);
            chk("bp_in_ready", sif8.in_ready, 0);
            chk("bp_diff_hold", sif8.diff, 8'h7A);
            chk("bp_flags_hold", {sif8.bout, sif8.ovf, sif8.zero}, {hb, ho, hz});
        end
        sif8.in_valid = 1'b0; sif8.out_ready = 1'b1;
        tick();
        chk("bp_hs_out_valid", sif8.out_valid, 0);
        chk("bp_hs_in_ready", sif8.in_ready, 1);
        tick();
        chk("bp_idle_stays", {sif8.out_valid, sif8.in_ready}, 2'b01);

        // Async reset three clocks into RUN.
        sif8.a = 8'h33; sif8.b = 8'h11; sif8.bin = 1'b0; sif8.in_valid = 1'b1;
        tick();
        sif8.in_valid = 1'b0;
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", sif8.out_valid, 0);
        chk("mid_rst_diff", sif8.diff, 0);
        chk("mid_rst_in_ready", sif8.in_ready, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("mid_rst_recover_ready", sif8.in_ready, 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("mid_rst_no_valid", sif8.out_valid, 0);
        end
        run8(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0);

        // Random sweep, four DIGIT variants in lock-step.
        for (int n = 0; n < 1000; n++) begin
            cyc = 0;
            while (sw_rdy != 4'hF && cyc < 20) begin tick(); cyc++; end
            chk("sw_in_ready", sw_rdy, 4'hF);
            sv_a = 16'($urandom); sv_b = 16'($urandom); sv_bin = 1'($urandom);
            if (n < 4) begin
                sv_a = (n[0]) ? 16'h8000 : 16'hFFFF;
                sv_b = (n[1]) ? 16'h0001 : 16'hFFFF;
            end
            sv_iv = 1'b1; sv_ordy = 1'b0;
            model(16, {16'h0, sv_a}, {16'h0, sv_b}, sv_bin, md, mb, mo, mz);
            tick();
            sv_iv = 1'b0;
            sv_a = ~sv_a; sv_b = ~sv_b;
            for (int k = 0; k < 4; k++) begin lat[k] = 0; done[k] = 1'b0; end
            all_done = 1'b0; cyc = 0;
            while (!all_done && cyc < 40) begin
                tick(); cyc++;
                all_done = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    if (!done[k] && sw_ov[k]) begin done[k] = 1'b1; lat[k] = cyc; end
                    if (!done[k]) all_done = 1'b0;
                end
            end
            for (int k = 0; k < 4; k++) begin
                chk("sw_latency", lat[k], (k == 3) ? 1 : (16 >> k));
                chk("sw_diff", sw_diff[k], md);
                chk("sw_bout", sw_bout[k], mb);
                chk("sw_ovf", sw_ovf[k], mo);
                chk("sw_zero", sw_zero[k], mz);
            end
            sv_ordy = 1'b1;
            tick();
            sv_ordy = 1'b0;
            chk("sw_hs_out_valid", sw_ov, 4'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Parametrised multi-cycle N-bit subtractor built from a chain of DIGIT full-subtract cells. It processes operands LSB-first, DIGIT bits per clock, and returns difference, borrow-out and status flags over a valid/ready handshake. It is the area-scalable sequential successor to the single-bit full subtractor, for datapaths that trade latency for gate count.

Parameters:
WIDTH, 16, operand and result width in bits; must be ≥ 2.
DIGIT, 1, bits processed per clock; 1 ≤ DIGIT ≤ WIDTH and WIDTH % DIGIT == 0 (elaboration error otherwise).

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands presented
in_ready  output  1  block can accept operands
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
bin  input  1  borrow-in
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
diff  output  WIDTH  a − b − bin, modulo 2^WIDTH
bout  output  1  final borrow; 1 iff unsigned a < b + bin
ovf  output  1  two's-complement overflow
zero  output  1  diff == 0

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; in_ready=1 once reset deasserts (0 while rst_n low); out_valid, diff, bout, ovf and zero all 0; internal counter, operand and borrow registers cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - capture a, b, bin into shift registers;
  - borrow register = bin; counter = 0; go to RUN.
- RUN: in_ready=0, out_valid=0. Each cycle:
  - take the low DIGIT bits of the a and b registers through DIGIT chained full-subtract cells:
    - d_i = a_i ^ b_i ^ br_i
    - br_{i+1} = (~a_i & b_i) | (~a_i & br_i) | (b_i & br_i)
  - shift the DIGIT result bits into the result register from the MSB side (after the last step, bit 0 is in bit 0);
  - shift the operand registers right by DIGIT;
  - store the final borrow; counter += 1.
  - When counter reaches WIDTH/DIGIT−1, this step is the last one; go to DONE.
- Latency: exactly WIDTH/DIGIT clocks from the accepting edge to out_valid=1. Example: WIDTH=16, DIGIT=1 gives 16; DIGIT=16 gives 1.
- DONE: out_valid=1, in_ready=0.
  - diff, bout, ovf and zero are stable and held until out_valid&&out_ready.
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the captured original a[MSB] and b[MSB]. bin does not alter the ovf rule.
  - zero = (diff == 0).
- Handshake in DONE: on out_valid&&out_ready, go to IDLE; out_valid drops next cycle; in_ready=1 from the next cycle. There are no back-to-back accepts; throughput is one operation per WIDTH/DIGIT+2 clocks.
- Result outputs retain their last value after handshake until the next DONE. Only out_valid qualifies them.
- in_valid is ignored in RUN and DONE: no capture and no side effect. a, b and bin may change freely after acceptance.
- out_ready is ignored outside DONE.
- Reset mid-RUN or mid-DONE aborts the operation: no out_valid, all outputs return to reset values, state IDLE.
- No X propagation: every register has a reset value.

Test Plan:
- WIDTH=8, DIGIT=1, a=0x05, b=0x03, bin=0, out_ready=1 -> out_valid exactly 8 clocks after accept; diff=0x02, bout=0, ovf=0, zero=0; in_ready back to 1 one clock after handshake.
- WIDTH=8, DIGIT=1, a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1, ovf=0. Then a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1, zero=0. Then a=0x07, b=0x06, bin=1 -> diff=0x00, zero=1, bout=0.
- Signed overflow, WIDTH=8: a=0x80, b=0x01, bin=0 -> diff=0x7F, ovf=1, bout=0. Then a=0x7F, b=0xFF -> diff=0x80, ovf=1, bout=1.
- Backpressure: hold out_ready=0 for 5 clocks in DONE while toggling in_valid and a/b -> out_valid stays 1; diff, bout, ovf and zero stay constant; in_ready stays 0; no new capture. Raise out_ready -> single handshake, then IDLE.
- Reset mid-operation: assert rst_n=0 asynchronously 3 clocks into RUN -> out_valid=0 and diff=0 immediately. After release, in_ready=1 and a fresh op a=0x10, b=0x01 gives diff=0x0F.
- Parameter sweep WIDTH=16 with DIGIT ∈ {1,2,4,16}: 1000 random a, b, bin each -> diff, bout and ovf match the reference model (a − b − bin mod 2^16, with flags); latency is 16, 8, 4 and 1 respectively.
